// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state type, bus widths
// and the lane-enable helper used when committing a write.
package bexkat1Def;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } resp_state_t;

   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;
   localparam int CNT_W  = 4;

   // Byte enables actually applied to the RAM: reads never touch any lane.
   function automatic logic [SEL_W-1:0] lane_enables(input logic we,
                                                     input logic [SEL_W-1:0] sel);
      logic [SEL_W-1:0] be;
      if (we) begin
         be = sel;
      end else begin
         be = {SEL_W{1'b0}};
      end
      return be;
   endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM with per-byte write enables and
// read-before-write output register, written to map onto block RAM.
module bus_ram
   import bexkat1Def::*;
#(
   parameter int AWIDTH = 10
) (
   input  logic              clk_i,
   input  logic [AWIDTH-1:0] addr,
   input  logic [SEL_W-1:0]  be,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [0:(2**AWIDTH)-1];

   // Byte-lane write and registered read of the same word; be bit i owns data[8i+7:8i].
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < SEL_W; i++) begin
         if (be[i]) begin
            mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      rdata <= mem_r[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Bus target: captures a request, waits WAIT_STATES cycles, then commits the
// write or returns the addressed word together with a one-cycle ack.
module mem_responder
   import bexkat1Def::*;
#(
   parameter int AWIDTH      = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              bus_cyc,
   input  logic              bus_we,
   input  logic [31:0]       bus_adr,
   input  logic [3:0]        bus_sel,
   input  logic [31:0]       bus_dat_i,
   output logic [31:0]       bus_dat_o,
   output logic              bus_ack
);

   localparam logic [CNT_W-1:0] WS_C = CNT_W'(WAIT_STATES);

   resp_state_t        state_r, state_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic               capture_s;
   logic               commit_s;
   logic               ack_r;

   logic [AWIDTH-1:0]  adr_r;
   logic               we_r;
   logic [SEL_W-1:0]   sel_r;
   logic [DATA_W-1:0]  dat_r;

   logic               use_bus_s;
   logic [AWIDTH-1:0]  ram_addr_s;
   logic               eff_we_s;
   logic [SEL_W-1:0]   eff_sel_s;
   logic [DATA_W-1:0]  eff_dat_s;
   logic [SEL_W-1:0]   ram_be_s;
   logic [DATA_W-1:0]  ram_q_s;
   logic               unused_adr_s;

   assign unused_adr_s = ^{bus_adr[31:AWIDTH+2], bus_adr[1:0]};

   // Next-state, wait counter and commit strobe.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      capture_s = 1'b0;
      commit_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus_cyc) begin
               capture_s = 1'b1;
               cnt_s     = WS_C;
               if (WS_C == {CNT_W{1'b0}}) begin
                  state_s  = ACK;
                  commit_s = 1'b1;
               end else begin
                  state_s  = WAIT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (!bus_cyc) begin
               state_s = IDLE;
               cnt_s   = {CNT_W{1'b0}};
            end else if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
               state_s  = ACK;
               cnt_s    = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               commit_s = 1'b1;
            end else begin
               state_s = WAIT;
               cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ACK: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, counter and ack registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         ack_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         ack_r   <= (state_s == ACK);
      end
   end

   // Request capture; later bus activity cannot disturb the transaction.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         adr_r <= {AWIDTH{1'b0}};
         we_r  <= 1'b0;
         sel_r <= {SEL_W{1'b0}};
         dat_r <= {DATA_W{1'b0}};
      end else if (capture_s) begin
         adr_r <= bus_adr[AWIDTH+1:2];
         we_r  <= bus_we;
         sel_r <= bus_sel;
         dat_r <= bus_dat_i;
      end
   end

   // In IDLE the RAM sees the live bus so a zero-wait access completes in time.
   always_comb begin
      use_bus_s = (state_r == IDLE);
      if (use_bus_s) begin
         ram_addr_s = bus_adr[AWIDTH+1:2];
         eff_we_s   = bus_we;
         eff_sel_s  = bus_sel;
         eff_dat_s  = bus_dat_i;
      end else begin
         ram_addr_s = adr_r;
         eff_we_s   = we_r;
         eff_sel_s  = sel_r;
         eff_dat_s  = dat_r;
      end
      if (commit_s && !rst_i) begin
         ram_be_s = lane_enables(eff_we_s, eff_sel_s);
      end else begin
         ram_be_s = {SEL_W{1'b0}};
      end
   end

   bus_ram #(
      .AWIDTH (AWIDTH)
   ) u_ram (
      .clk_i (clk_i),
      .addr  (ram_addr_s),
      .be    (ram_be_s),
      .wdata (eff_dat_s),
      .rdata (ram_q_s)
   );

   assign bus_ack   = ack_r;
   assign bus_dat_o = ack_r ? ram_q_s : 32'h0000_0000;

endmodule
